// File: rtl/ddr_init_sequencer.sv
// DDR4 power-up sequencer: RESET_n/CKE ramp, MR3..MR0 programming, ZQCL, then init_done.
// All outputs are registered; a single down-counter times every wait state.
module ddr_init_sequencer #(
    parameter int unsigned tCCD         = 4,
    parameter int unsigned WR_DLY       = 10,
    parameter int unsigned RD_DLY       = 13,
    parameter logic        W_PRE        = 1'b1,
    parameter logic        R_PRE        = 1'b1,
    parameter logic [1:0]  BURST_LENGTH = 2'b00,
    parameter logic [1:0]  AL_DLY       = 2'b00,
    parameter int unsigned T_RESET      = 200,
    parameter int unsigned T_CKE        = 500,
    parameter int unsigned T_XPR        = 20,
    parameter int unsigned T_MRD        = 8,
    parameter int unsigned T_MOD        = 24,
    parameter int unsigned T_ZQINIT     = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        dram_reset_n,
    output logic        cke,
    output logic        cs_n,
    output logic        act_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  bg,
    output logic [1:0]  ba,
    output logic [13:0] addr,
    output logic        odt,
    output logic        cmd_valid,
    output logic        init_done
);

    if (tCCD < 4 || tCCD > 8) begin : g_bad_tccd
        $error("tCCD out of range 4..8");
    end
    if (WR_DLY < 9 || WR_DLY > 12) begin : g_bad_wr
        $error("WR_DLY out of range 9..12");
    end
    if (RD_DLY < 9 || RD_DLY > 16) begin : g_bad_rd
        $error("RD_DLY out of range 9..16");
    end
    if (T_RESET < 1 || T_CKE < 1 || T_XPR < 1 || T_MRD < 1 || T_MOD < 1 || T_ZQINIT < 1 ||
        T_RESET > 65536 || T_CKE > 65536 || T_XPR > 65536 || T_MRD > 65536 ||
        T_MOD > 65536 || T_ZQINIT > 65536) begin : g_bad_t
        $error("timing parameters must be in 1..65536");
    end

    typedef enum logic [2:0] {
        RESET_HOLD,
        CKE_WAIT,
        XPR_WAIT,
        MRD_WAIT,
        MOD_WAIT,
        ZQ_WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  mrs_idx_q;
    logic        dram_reset_n_q, cke_q, cmd_valid_q, init_done_q;
    logic        cs_n_q, act_n_q, ras_n_q, cas_n_q, we_n_q;
    logic [1:0]  bg_q, ba_q;
    logic [13:0] addr_q;
    logic [3:0]  mr_bgba_d;
    logic [13:0] mr_addr_d;

    // Issue order MR3, MR6, MR5, MR4, MR2, MR1, MR0 indexed by mrs_idx_q.
    always_comb begin
        mr_bgba_d = '0;
        mr_addr_d = '0;
        case (mrs_idx_q)
            3'd0: mr_bgba_d = 4'b0011;
            3'd1: begin
                mr_bgba_d         = 4'b0110;
                mr_addr_d[12:10]  = 3'(tCCD - 4);
            end
            3'd2: mr_bgba_d = 4'b0101;
            3'd3: begin
                mr_bgba_d     = 4'b0100;
                mr_addr_d[12] = W_PRE;
                mr_addr_d[11] = R_PRE;
            end
            3'd4: begin
                mr_bgba_d      = 4'b0010;
                mr_addr_d[5:3] = 3'(WR_DLY - 9);
            end
            3'd5: begin
                mr_bgba_d      = 4'b0001;
                mr_addr_d[0]   = 1'b1;
                mr_addr_d[4:3] = AL_DLY;
            end
            3'd6: begin
                mr_bgba_d      = 4'b0000;
                mr_addr_d[1:0] = BURST_LENGTH;
                mr_addr_d[6:4] = 3'(RD_DLY - 9);
            end
            default: ;
        endcase
    end

    // Command issue happens on the edge where the preceding wait expires, so a
    // one-cycle wait yields back-to-back commands with no separate issue cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RESET_HOLD;
            cnt_q          <= 16'(T_RESET - 1);
            mrs_idx_q      <= '0;
            dram_reset_n_q <= 1'b0;
            cke_q          <= 1'b0;
            cmd_valid_q    <= 1'b0;
            init_done_q    <= 1'b0;
            cs_n_q         <= 1'b1;
            act_n_q        <= 1'b1;
            ras_n_q        <= 1'b1;
            cas_n_q        <= 1'b1;
            we_n_q         <= 1'b1;
            bg_q           <= '0;
            ba_q           <= '0;
            addr_q         <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            act_n_q     <= 1'b1;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            bg_q        <= '0;
            ba_q        <= '0;
            addr_q      <= '0;
            if (state_q != DONE && cnt_q != 16'd0) begin
                cnt_q <= cnt_q - 16'd1;
            end else begin
                case (state_q)
                    RESET_HOLD: begin
                        dram_reset_n_q <= 1'b1;
                        state_q        <= CKE_WAIT;
                        cnt_q          <= 16'(T_CKE - 1);
                    end
                    CKE_WAIT: begin
                        cke_q   <= 1'b1;
                        state_q <= XPR_WAIT;
                        cnt_q   <= 16'(T_XPR - 1);
                    end
                    XPR_WAIT, MRD_WAIT: begin
                        cmd_valid_q <= 1'b1;
                        cs_n_q      <= 1'b0;
                        ras_n_q     <= 1'b0;
                        cas_n_q     <= 1'b0;
                        we_n_q      <= 1'b0;
                        {bg_q, ba_q} <= mr_bgba_d;
                        addr_q      <= mr_addr_d;
                        if (mrs_idx_q == 3'd6) begin
                            state_q <= MOD_WAIT;
                            cnt_q   <= 16'(T_MOD - 1);
                        end else begin
                            mrs_idx_q <= mrs_idx_q + 3'd1;
                            state_q   <= MRD_WAIT;
                            cnt_q     <= 16'(T_MRD - 1);
                        end
                    end
                    MOD_WAIT: begin
                        cmd_valid_q <= 1'b1;
                        cs_n_q      <= 1'b0;
                        we_n_q      <= 1'b0;
                        addr_q      <= 14'h0400;
                        state_q     <= ZQ_WAIT;
                        cnt_q       <= 16'(T_ZQINIT - 1);
                    end
                    ZQ_WAIT: begin
                        init_done_q <= 1'b1;
                        state_q     <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dram_reset_n = dram_reset_n_q;
    assign cke          = cke_q;
    assign cs_n         = cs_n_q;
    assign act_n        = act_n_q;
    assign ras_n        = ras_n_q;
    assign cas_n        = cas_n_q;
    assign we_n         = we_n_q;
    assign bg           = bg_q;
    assign ba           = ba_q;
    assign addr         = addr_q;
    assign odt          = 1'b0;
    assign cmd_valid    = cmd_valid_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer: per-edge event-schedule model, MRS payload table,
// async mid-sequence reset, randomized resets on a short-timing instance.
module tb_ddr_init_sequencer;

    typedef struct packed {
        logic        drst, cke, cs_n, act_n, ras_n, cas_n, we_n;
        logic [1:0]  bg, ba;
        logic [13:0] addr;
        logic        odt, cmd_valid, init_done;
    } out_t;

    typedef struct {
        int unsigned tr, tc, tx, tmrd, tmod, tzq;
    } tim_t;

    typedef struct {
        int unsigned inst;
        int unsigned k;
        logic [17:0] exp;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_def, r_cus, r_one;
    out_t o_def, o_cus, o_one;

    ddr_init_sequencer u_def (
        .clock(clk), .reset_n(r_def), .dram_reset_n(o_def.drst), .cke(o_def.cke),
        .cs_n(o_def.cs_n), .act_n(o_def.act_n), .ras_n(o_def.ras_n), .cas_n(o_def.cas_n),
        .we_n(o_def.we_n), .bg(o_def.bg), .ba(o_def.ba), .addr(o_def.addr), .odt(o_def.odt),
        .cmd_valid(o_def.cmd_valid), .init_done(o_def.init_done)
    );

    ddr_init_sequencer #(
        .tCCD(6), .WR_DLY(12), .RD_DLY(16), .W_PRE(1'b0), .R_PRE(1'b1),
        .BURST_LENGTH(2'b10), .AL_DLY(2'b01),
        .T_RESET(3), .T_CKE(5), .T_XPR(2), .T_MRD(3), .T_MOD(4), .T_ZQINIT(6)
    ) u_cus (
        .clock(clk), .reset_n(r_cus), .dram_reset_n(o_cus.drst), .cke(o_cus.cke),
        .cs_n(o_cus.cs_n), .act_n(o_cus.act_n), .ras_n(o_cus.ras_n), .cas_n(o_cus.cas_n),
        .we_n(o_cus.we_n), .bg(o_cus.bg), .ba(o_cus.ba), .addr(o_cus.addr), .odt(o_cus.odt),
        .cmd_valid(o_cus.cmd_valid), .init_done(o_cus.init_done)
    );

    ddr_init_sequencer #(
        .T_RESET(1), .T_CKE(1), .T_XPR(1), .T_MRD(1), .T_MOD(1), .T_ZQINIT(1)
    ) u_one (
        .clock(clk), .reset_n(r_one), .dram_reset_n(o_one.drst), .cke(o_one.cke),
        .cs_n(o_one.cs_n), .act_n(o_one.act_n), .ras_n(o_one.ras_n), .cas_n(o_one.cas_n),
        .we_n(o_one.we_n), .bg(o_one.bg), .ba(o_one.ba), .addr(o_one.addr), .odt(o_one.odt),
        .cmd_valid(o_one.cmd_valid), .init_done(o_one.init_done)
    );

    tim_t T_DEF, T_CUS, T_ONE;
    int unsigned n_def = 0, n_cus = 0, n_one = 0;
    logic [17:0] q_def[$], q_cus[$], q_one[$];
    vec_t tbl[$];
    int unsigned hold = 2, rnd_left = 6, pulses = 0;
    logic phase2 = 1'b0;

    // Expected pins at edge n from the event schedule; MRS payload is checked via the table.
    function automatic out_t model(int unsigned n, tim_t t);
        out_t o;
        int unsigned t_cke, t_mr3, t_zq;
        t_cke = t.tr + t.tc;
        t_mr3 = t_cke + t.tx;
        t_zq  = t_mr3 + 6 * t.tmrd + t.tmod;
        o = '0;
        o.drst = (n >= t.tr);
        o.cke  = (n >= t_cke);
        o.cs_n = 1'b1; o.act_n = 1'b1; o.ras_n = 1'b1; o.cas_n = 1'b1; o.we_n = 1'b1;
        if (n >= t_mr3 && n <= t_mr3 + 6 * t.tmrd && (n - t_mr3) % t.tmrd == 0) begin
            o.cs_n = 1'b0; o.ras_n = 1'b0; o.cas_n = 1'b0; o.we_n = 1'b0;
            o.cmd_valid = 1'b1;
        end else if (n == t_zq) begin
            o.cs_n = 1'b0; o.we_n = 1'b0; o.addr = 14'h0400;
            o.cmd_valid = 1'b1;
        end
        o.init_done = (n >= t_zq + t.tzq);
        return o;
    endfunction

    function automatic logic is_mrs(out_t e);
        return e.cmd_valid && !e.ras_n;
    endfunction

    task automatic check_out(input string nm, input int unsigned n, input out_t exp,
                             input out_t act, output logic [17:0] pay);
        out_t a;
        a   = act;
        pay = {act.bg, act.ba, act.addr};
        if (is_mrs(exp)) begin
            a.bg = '0; a.ba = '0; a.addr = '0;
        end
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h exp=%h", nm, n, a, exp);
        end
    endtask

    task automatic step();
        logic [17:0] p;
        out_t e;
        @(posedge clk);
        if (r_def) n_def++;
        if (r_cus) n_cus++;
        if (r_one) n_one++;
        #1;
        e = model(n_def, T_DEF);
        check_out("def_cycle", n_def, e, o_def, p);
        if (is_mrs(e)) q_def.push_back(p);
        e = model(n_cus, T_CUS);
        check_out("cus_cycle", n_cus, e, o_cus, p);
        if (is_mrs(e)) q_cus.push_back(p);
        e = model(n_one, T_ONE);
        check_out("one_cycle", n_one, e, o_one, p);
        if (is_mrs(e)) q_one.push_back(p);
        if (phase2 && o_def.cmd_valid) pulses++;
        if (!r_cus) begin
            if (hold == 0) r_cus = 1'b1;
            else hold--;
        end else if (rnd_left > 0 && n_cus > 0 && $urandom_range(0, 29) == 0) begin
            r_cus = 1'b0;
            rnd_left--;
            hold = $urandom_range(0, 3);
            #1;
            check_out("cus_async_rst", n_cus, model(0, T_CUS), o_cus, p);
            n_cus = 0;
            q_cus.delete();
        end
    endtask

    task automatic add(input int unsigned inst, input int unsigned k,
                       input logic [1:0] bg, input logic [1:0] ba, input logic [13:0] a);
        vec_t v;
        v.inst = inst; v.k = k; v.exp = {bg, ba, a};
        tbl.push_back(v);
    endtask

    initial begin
        logic [17:0] p;
        logic [17:0] got;
        T_DEF = '{200, 500, 20, 8, 24, 1024};
        T_CUS = '{3, 5, 2, 3, 4, 6};
        T_ONE = '{1, 1, 1, 1, 1, 1};
        for (int unsigned inst = 0; inst < 3; inst++) begin
            if (inst == 1) begin
                add(1, 0, 2'b00, 2'b11, 14'h0000);
                add(1, 1, 2'b01, 2'b10, 14'h0800);
                add(1, 2, 2'b01, 2'b01, 14'h0000);
                add(1, 3, 2'b01, 2'b00, 14'h0800);
                add(1, 4, 2'b00, 2'b10, 14'h0018);
                add(1, 5, 2'b00, 2'b01, 14'h0009);
                add(1, 6, 2'b00, 2'b00, 14'h0072);
            end else begin
                add(inst, 0, 2'b00, 2'b11, 14'h0000);
                add(inst, 1, 2'b01, 2'b10, 14'h0000);
                add(inst, 2, 2'b01, 2'b01, 14'h0000);
                add(inst, 3, 2'b01, 2'b00, 14'h1800);
                add(inst, 4, 2'b00, 2'b10, 14'h0008);
                add(inst, 5, 2'b00, 2'b01, 14'h0001);
                add(inst, 6, 2'b00, 2'b00, 14'h0040);
            end
        end

        r_def = 1'b0; r_cus = 1'b0; r_one = 1'b0;
        repeat (3) step();
        r_def = 1'b1; r_one = 1'b1;
        while (n_def < 736) step();

        // Edge 736 carries MR5; reset must clear outputs without a clock edge.
        r_def = 1'b0;
        #1;
        check_out("def_async_rst", n_def, model(0, T_DEF), o_def, p);
        n_def = 0;
        q_def.delete();
        repeat (4) step();
        r_def  = 1'b1;
        phase2 = 1'b1;
        while (n_def < 1816 + 5000) step();

        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL cmd_pulses got=%0d exp=8", pulses);
        end
        checks++;
        if (q_def.size() != 7 || q_cus.size() != 7 || q_one.size() != 7) begin
            errors++;
            $display("FAIL mrs_count got=%0d/%0d/%0d exp=7/7/7", q_def.size(), q_cus.size(), q_one.size());
        end
        for (int i = 0; i < tbl.size(); i++) begin
            got = '1;
            case (tbl[i].inst)
                0: if (tbl[i].k < q_def.size()) got = q_def[tbl[i].k];
                1: if (tbl[i].k < q_cus.size()) got = q_cus[tbl[i].k];
                default: if (tbl[i].k < q_one.size()) got = q_one[tbl[i].k];
            endcase
            checks++;
            if (got !== tbl[i].exp) begin
                errors++;
                $display("FAIL mrs_payload inst=%0d idx=%0d got=%h exp=%h", tbl[i].inst, tbl[i].k, got, tbl[i].exp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
